biriscv_pipe_track: RTL and testbench

Depth-parametrised in-order execution tracker for the biRISC-V issue/commit path. It carries issued instructions through `DEPTH` stages: stage 1 is the youngest and stage `DEPTH` is the commit stage. It captures results that arrive after issue (mul/div/load), provides register-forwarding lookups across all stages, stalls when the commit stage is waiting on a result, and flushes on commit-time exceptions or external squash.

---
 rtl/biriscv_pipe_track_if.sv | 34 +++
 rtl/biriscv_pipe_track.sv | 147 ++++++++++++++
 tb/tb_biriscv_pipe_track.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_pipe_track_if.sv
// Issue and commit bus of the biRISC-V pipeline tracker.
// Signal suffixes are named from the tracker's point of view (slave modport).
interface biriscv_pipe_track_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid_i;
  logic              issue_accept_o;
  logic              issue_rd_valid_i;
  logic [4:0]        issue_rd_i;
  logic              issue_late_i;
  logic [DATA_W-1:0] issue_result_i;
  logic [DATA_W-1:0] issue_pc_i;
  logic [5:0]        issue_exception_i;

  logic              commit_valid_o;
  logic [4:0]        commit_rd_o;
  logic [DATA_W-1:0] commit_result_o;
  logic [DATA_W-1:0] commit_pc_o;
  logic [5:0]        commit_exception_o;

  modport master (
    output issue_valid_i, issue_rd_valid_i, issue_rd_i, issue_late_i,
           issue_result_i, issue_pc_i, issue_exception_i,
    input  issue_accept_o,
           commit_valid_o, commit_rd_o, commit_result_o, commit_pc_o, commit_exception_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_valid_i, issue_rd_i, issue_late_i,
           issue_result_i, issue_pc_i, issue_exception_i,
    output issue_accept_o,
           commit_valid_o, commit_rd_o, commit_result_o, commit_pc_o, commit_exception_o
  );
endinterface

// File: rtl/biriscv_pipe_track.sv
// In-order issue-to-commit tracker: late-result capture, forwarding, stall and flush.
// Define BIRISCV_PIPE_FWD_EN to enable forwarding ready/value; otherwise only hits are reported.
module biriscv_pipe_track #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  biriscv_pipe_track_if.slave bus,
  input  logic              issue_stall_i,
  input  logic              late_valid_i,
  input  logic [DATA_W-1:0] late_result_i,
  input  logic [5:0]        late_exception_i,
  input  logic [4:0]        ra_idx_i,
  input  logic [4:0]        rb_idx_i,
  output logic              ra_hit_o,
  output logic              rb_hit_o,
  output logic              ra_ready_o,
  output logic              rb_ready_o,
  output logic [DATA_W-1:0] ra_value_o,
  output logic [DATA_W-1:0] rb_value_o,
  output logic              stall_o,
  input  logic              squash_i
);

  typedef struct packed {
    logic              valid;
    logic              rd_valid;
    logic [4:0]        rd;
    logic              pending;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] pc;
    logic [5:0]        exc;
  } stage_t;

  // Index 0 is the youngest stage, DEPTH-1 the commit stage.
  stage_t stage_q [DEPTH];
  stage_t stage_d [DEPTH];
  stage_t head;

  logic [DEPTH-1:0]  late_sel;
  logic [DATA_W-1:0] head_result;
  logic [5:0]        head_exc;
  logic              commit_valid;
  logic              commit_exc;
  logic              adv;
  logic              accept;

  assign head = stage_q[DEPTH-1];

  // Oldest valid stage still waiting for its late result.
  always_comb begin
    late_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stage_q[k].valid && stage_q[k].pending) begin
        late_sel    = '0;
        late_sel[k] = 1'b1;
      end
    end
  end

  assign stall_o      = head.valid & head.pending & ~late_valid_i;
  assign head_result  = head.pending ? late_result_i : head.result;
  assign head_exc     = (head.pending && head.exc == 6'd0) ? late_exception_i : head.exc;
  assign commit_valid = head.valid & (~head.pending | late_valid_i) & ~issue_stall_i
                      & ~squash_i & ~rst_i;
  assign commit_exc   = commit_valid & (head_exc != 6'd0);
  assign adv          = ~issue_stall_i & ~stall_o;
  assign accept       = adv & ~squash_i & ~commit_exc;

  assign bus.issue_accept_o     = accept;
  assign bus.commit_valid_o     = commit_valid;
  assign bus.commit_rd_o        = (commit_valid && head.rd_valid && head_exc == 6'd0) ? head.rd : 5'd0;
  assign bus.commit_result_o    = commit_valid ? head_result : '0;
  assign bus.commit_pc_o        = commit_valid ? head.pc : '0;
  assign bus.commit_exception_o = commit_valid ? head_exc : 6'd0;

  // Forwarding: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    ra_hit_o   = 1'b0;
    rb_hit_o   = 1'b0;
    ra_ready_o = 1'b0;
    rb_ready_o = 1'b0;
    ra_value_o = '0;
    rb_value_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stage_q[k].valid && stage_q[k].rd_valid && ra_idx_i != 5'd0 && stage_q[k].rd == ra_idx_i) begin
        ra_hit_o = 1'b1;
`ifdef BIRISCV_PIPE_FWD_EN
        ra_ready_o = ~stage_q[k].pending | (late_valid_i & late_sel[k]);
        ra_value_o = (stage_q[k].pending && late_valid_i && late_sel[k]) ? late_result_i
                                                                          : stage_q[k].result;
`endif
      end
      if (stage_q[k].valid && stage_q[k].rd_valid && rb_idx_i != 5'd0 && stage_q[k].rd == rb_idx_i) begin
        rb_hit_o = 1'b1;
`ifdef BIRISCV_PIPE_FWD_EN
        rb_ready_o = ~stage_q[k].pending | (late_valid_i & late_sel[k]);
        rb_value_o = (stage_q[k].pending && late_valid_i && late_sel[k]) ? late_result_i
                                                                          : stage_q[k].result;
`endif
      end
    end
  end

  always_comb begin
    // NOTE: default every next-state element to its current value first so no path infers a latch.
    stage_d = stage_q;
    if (squash_i) begin
      for (int k = 0; k < DEPTH; k++) stage_d[k].valid = 1'b0;
    end else if (!issue_stall_i) begin
      // Late capture is applied before the shift so it travels with its entry.
      if (late_valid_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (late_sel[k]) begin
            stage_d[k].result  = late_result_i;
            stage_d[k].pending = 1'b0;
            if (stage_d[k].exc == 6'd0) stage_d[k].exc = late_exception_i;
          end
        end
      end
      if (adv) begin
        for (int k = DEPTH - 1; k > 0; k--) stage_d[k] = stage_d[k-1];
        stage_d[0].valid    = bus.issue_valid_i & accept;
        stage_d[0].rd_valid = bus.issue_rd_valid_i;
        stage_d[0].rd       = bus.issue_rd_i;
        stage_d[0].pending  = bus.issue_late_i;
        stage_d[0].result   = bus.issue_result_i;
        stage_d[0].pc       = bus.issue_pc_i;
        stage_d[0].exc      = bus.issue_exception_i;
        if (commit_exc) begin
          for (int k = 0; k < DEPTH; k++) stage_d[k].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: only the valid bits are reset; payload is never observed while valid is low.
      for (int k = 0; k < DEPTH; k++) stage_q[k].valid <= 1'b0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_biriscv_pipe_track.sv
// Self-checking bench for biriscv_pipe_track (DEPTH=3): queue-based reference model
// compared every cycle, plus directed literal checks for each scenario.
module tb_biriscv_pipe_track;
  localparam int DEPTH  = 3;
  localparam int DATA_W = 32;
`ifdef BIRISCV_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk;
  logic              rst_i;
  logic              issue_stall_i;
  logic              late_valid_i;
  logic [DATA_W-1:0] late_result_i;
  logic [5:0]        late_exception_i;
  logic [4:0]        ra_idx_i, rb_idx_i;
  logic              ra_hit_o, rb_hit_o, ra_ready_o, rb_ready_o;
  logic [DATA_W-1:0] ra_value_o, rb_value_o;
  logic              stall_o;
  logic              squash_i;

  biriscv_pipe_track_if #(.DATA_W(DATA_W)) bus ();

  biriscv_pipe_track #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .bus              (bus.slave),
    .issue_stall_i    (issue_stall_i),
    .late_valid_i     (late_valid_i),
    .late_result_i    (late_result_i),
    .late_exception_i (late_exception_i),
    .ra_idx_i         (ra_idx_i),
    .rb_idx_i         (rb_idx_i),
    .ra_hit_o         (ra_hit_o),
    .rb_hit_o         (rb_hit_o),
    .ra_ready_o       (ra_ready_o),
    .rb_ready_o       (rb_ready_o),
    .ra_value_o       (ra_value_o),
    .rb_value_o       (rb_value_o),
    .stall_o          (stall_o),
    .squash_i         (squash_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in issue order, each tagged with its stage.
  typedef struct {
    bit        rd_valid;
    bit [4:0]  rd;
    bit        pending;
    bit [31:0] result;
    bit [31:0] pc;
    bit [5:0]  exc;
    int        stage;
  } ent_t;

  ent_t q[$];

  bit        e_cv, e_stall, e_acc, e_cexc;
  bit [4:0]  e_rd;
  bit [31:0] e_res, e_pc;
  bit [5:0]  e_exc;
  bit        e_ra_hit, e_ra_rdy, e_rb_hit, e_rb_rdy;
  bit [31:0] e_ra_val, e_rb_val;
  int        late_tgt;

  task automatic fwd(input bit [4:0] idx, output bit hit, output bit rdy, output bit [31:0] val);
    hit = 1'b0; rdy = 1'b0; val = '0;
    if (idx != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].rd_valid && q[i].rd == idx) begin
          hit = 1'b1;
          if (FWD) begin
            if (q[i].pending && late_valid_i && i == late_tgt) begin
              rdy = 1'b1; val = late_result_i;
            end else begin
              rdy = !q[i].pending; val = q[i].result;
            end
          end
          break;
        end
      end
    end
  endtask

  task automatic model_eval();
    ent_t h;
    bit   has_head;
    bit [5:0]  x;
    h = '{default: 0};
    has_head = (q.size() > 0) && (q[0].stage == DEPTH);
    if (has_head) h = q[0];
    e_stall = has_head && h.pending && !late_valid_i;
    e_cv    = has_head && (!h.pending || late_valid_i) && !issue_stall_i && !squash_i && !rst_i;
    x       = h.pending ? ((h.exc != 0) ? h.exc : late_exception_i) : h.exc;
    e_res   = e_cv ? (h.pending ? late_result_i : h.result) : 32'd0;
    e_pc    = e_cv ? h.pc : 32'd0;
    e_exc   = e_cv ? x : 6'd0;
    e_rd    = (e_cv && h.rd_valid && x == 0) ? h.rd : 5'd0;
    e_cexc  = e_cv && (x != 0);
    e_acc   = !issue_stall_i && !e_stall && !squash_i && !e_cexc;
    late_tgt = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].pending) begin late_tgt = i; break; end
    end
    fwd(ra_idx_i, e_ra_hit, e_ra_rdy, e_ra_val);
    fwd(rb_idx_i, e_rb_hit, e_rb_rdy, e_rb_val);
  endtask

  always @(posedge clk) begin
    ent_t n;
    model_eval();
    if (rst_i || squash_i) begin
      q.delete();
    end else if (!issue_stall_i) begin
      if (late_valid_i && late_tgt >= 0) begin
        n = q[late_tgt];
        n.result  = late_result_i;
        n.pending = 1'b0;
        if (n.exc == 0) n.exc = late_exception_i;
        q[late_tgt] = n;
      end
      if (!e_stall) begin
        for (int i = 0; i < q.size(); i++) q[i].stage = q[i].stage + 1;
        while (q.size() > 0 && q[0].stage > DEPTH) void'(q.pop_front());
        if (e_cexc) q.delete();
        else if (bus.issue_valid_i && e_acc) begin
          n = '{rd_valid: bus.issue_rd_valid_i, rd: bus.issue_rd_i, pending: bus.issue_late_i,
                result: bus.issue_result_i, pc: bus.issue_pc_i, exc: bus.issue_exception_i, stage: 1};
          q.push_back(n);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst_i) begin
      model_eval();
      check("commit_valid", bus.commit_valid_o, e_cv);
      check("commit_rd", bus.commit_rd_o, e_rd);
      check("commit_result", bus.commit_result_o, e_res);
      check("commit_pc", bus.commit_pc_o, e_pc);
      check("commit_exc", bus.commit_exception_o, e_exc);
      check("stall", stall_o, e_stall);
      check("accept", bus.issue_accept_o, e_acc);
      check("ra_hit", ra_hit_o, e_ra_hit);
      check("ra_ready", ra_ready_o, e_ra_rdy);
      check("ra_value", ra_value_o, e_ra_val);
      check("rb_hit", rb_hit_o, e_rb_hit);
      check("rb_ready", rb_ready_o, e_rb_rdy);
      check("rb_value", rb_value_o, e_rb_val);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid_i     = 1'b0;
    bus.issue_rd_valid_i  = 1'b0;
    bus.issue_rd_i        = 5'd0;
    bus.issue_late_i      = 1'b0;
    bus.issue_result_i    = '0;
    bus.issue_pc_i        = '0;
    bus.issue_exception_i = 6'd0;
    issue_stall_i         = 1'b0;
    late_valid_i          = 1'b0;
    late_result_i         = '0;
    late_exception_i      = 6'd0;
    squash_i              = 1'b0;
  endtask

  task automatic issue(input bit [4:0] rd, input bit late, input bit [31:0] res,
                       input bit [31:0] pc, input bit [5:0] exc);
    idle();
    bus.issue_valid_i     = 1'b1;
    bus.issue_rd_valid_i  = 1'b1;
    bus.issue_rd_i        = rd;
    bus.issue_late_i      = late;
    bus.issue_result_i    = res;
    bus.issue_pc_i        = pc;
    bus.issue_exception_i = exc;
  endtask

  initial begin
    rst_i = 1'b1; ra_idx_i = 5'd0; rb_idx_i = 5'd0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    run_cmp = 1'b1;

    // Reset state
    ra_idx_i = 5'd5; rb_idx_i = 5'd7;
    #1;
    check("rst commit_valid", bus.commit_valid_o, 1'b0);
    check("rst commit_result", bus.commit_result_o, 32'd0);
    check("rst stall", stall_o, 1'b0);
    check("rst ra_hit", ra_hit_o, 1'b0);
    check("rst accept", bus.issue_accept_o, 1'b1);
    issue_stall_i = 1'b1;
    #1 check("rst accept stalled", bus.issue_accept_o, 1'b0);

    // Simple issue, forward, commit
    cyc(); issue(5'd5, 1'b0, 32'h11, 32'h100, 6'd0);
    cyc(); idle();
    #1 check("s1 hit", ra_hit_o, 1'b1);
    check("s1 ready", ra_ready_o, FWD);
    check("s1 value", ra_value_o, FWD ? 32'h11 : 32'h0);
    cyc(); cyc();
    check("s1 commit_valid", bus.commit_valid_o, 1'b1);
    check("s1 commit_rd", bus.commit_rd_o, 5'd5);
    check("s1 commit_result", bus.commit_result_o, 32'h11);
    check("s1 commit_pc", bus.commit_pc_o, 32'h100);
    cyc();
    check("s1 drained", bus.commit_valid_o, 1'b0);

    // Late result stalls the commit stage
    cyc(); issue(5'd7, 1'b1, 32'h0, 32'h200, 6'd0);
    cyc(); idle(); cyc(); cyc();
    check("s2 stall", stall_o, 1'b1);
    check("s2 accept", bus.issue_accept_o, 1'b0);
    check("s2 rb ready", rb_ready_o, 1'b0);
    cyc();
    check("s2 still stall", stall_o, 1'b1);
    cyc(); late_valid_i = 1'b1; late_result_i = 32'hAB;
    #1 check("s2 commit_valid", bus.commit_valid_o, 1'b1);
    check("s2 commit_rd", bus.commit_rd_o, 5'd7);
    check("s2 commit_result", bus.commit_result_o, 32'hAB);
    check("s2 stall off", stall_o, 1'b0);
    check("s2 rb value", rb_value_o, FWD ? 32'hAB : 32'h0);
    cyc(); late_valid_i = 1'b1; late_result_i = 32'hCD;
    #1 check("s2 stray strobe", bus.commit_valid_o, 1'b0);

    // Youngest match wins; index 0 never hits
    cyc(); issue(5'd3, 1'b0, 32'h1, 32'h300, 6'd0);
    cyc(); issue(5'd3, 1'b0, 32'h2, 32'h304, 6'd0);
    cyc(); idle(); ra_idx_i = 5'd3; rb_idx_i = 5'd0;
    #1 check("s3 hit", ra_hit_o, 1'b1);
    check("s3 value", ra_value_o, FWD ? 32'h2 : 32'h0);
    check("s3 idx0", rb_hit_o, 1'b0);
    repeat (3) cyc();

    // Commit-time exception flushes younger entries
    cyc(); issue(5'd9, 1'b0, 32'h55, 32'h400, 6'd2);
    cyc(); issue(5'd10, 1'b0, 32'h56, 32'h404, 6'd0);
    cyc(); issue(5'd11, 1'b0, 32'h57, 32'h408, 6'd0);
    cyc(); idle();
    #1 check("s4 commit_valid", bus.commit_valid_o, 1'b1);
    check("s4 commit_exc", bus.commit_exception_o, 6'd2);
    check("s4 commit_rd", bus.commit_rd_o, 5'd0);
    check("s4 accept", bus.issue_accept_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("s4 flushed", bus.commit_valid_o, 1'b0);
    end

    // Squash with a late strobe in the same cycle
    ra_idx_i = 5'd13; rb_idx_i = 5'd12;
    cyc(); issue(5'd12, 1'b0, 32'h60, 32'h500, 6'd0);
    cyc(); issue(5'd13, 1'b1, 32'h0, 32'h504, 6'd0);
    cyc(); issue(5'd14, 1'b0, 32'h62, 32'h508, 6'd0);
    cyc(); idle(); squash_i = 1'b1; late_valid_i = 1'b1; late_result_i = 32'hEE;
    #1 check("s5 squash commit", bus.commit_valid_o, 1'b0);
    check("s5 squash accept", bus.issue_accept_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); idle();
      #1 check("s5 no commit", bus.commit_valid_o, 1'b0);
      check("s5 no hit", ra_hit_o, 1'b0);
    end

    // External hold freezes everything
    cyc(); issue(5'd1, 1'b0, 32'h61, 32'h600, 6'd0);
    cyc(); issue(5'd2, 1'b0, 32'h62, 32'h604, 6'd0);
    cyc(); issue(5'd4, 1'b0, 32'h63, 32'h608, 6'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); idle(); issue_stall_i = 1'b1;
      #1 check("s6 held", bus.commit_valid_o, 1'b0);
    end
    cyc(); idle();
    #1 check("s6 pc0", bus.commit_pc_o, 32'h600);
    cyc(); check("s6 pc1", bus.commit_pc_o, 32'h604);
    cyc(); check("s6 pc2", bus.commit_pc_o, 32'h608);
    cyc(); check("s6 done", bus.commit_valid_o, 1'b0);

    // Late results captured before the entry reaches commit
    cyc(); issue(5'd20, 1'b1, 32'h0, 32'h700, 6'd0);
    cyc(); issue(5'd21, 1'b1, 32'h0, 32'h704, 6'd0); late_valid_i = 1'b1; late_result_i = 32'h70;
    cyc(); idle(); late_valid_i = 1'b1; late_result_i = 32'h71;
    cyc(); idle();
    #1 check("s8 first result", bus.commit_result_o, 32'h70);
    check("s8 first rd", bus.commit_rd_o, 5'd20);
    cyc(); check("s8 second result", bus.commit_result_o, 32'h71);
    check("s8 second rd", bus.commit_rd_o, 5'd21);

    // Reset mid-flight drops entries
    cyc(); issue(5'd22, 1'b0, 32'h80, 32'h800, 6'd0);
    cyc(); issue(5'd23, 1'b0, 32'h81, 32'h804, 6'd0);
    cyc(); idle(); rst_i = 1'b1;
    cyc(); rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("s7 dropped", bus.commit_valid_o, 1'b0);
      cyc();
    end

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
